// File: rtl/dnlink_pcm_sim.sv
// -----------------------------------------------------------------------------
// dnlink_pcm_sim
// Simulated PCM telemetry unit for the AGC downlink. Generates the DKSTRT,
// DKBSNC and DKEND timing pulses, samples DKDATA once per bit time (MSB
// first), and hands each finished packet to the monitor through a one-entry
// valid/ready buffer. Drops while the buffer is full set a sticky overrun.
//
// Optional build macro: DNLINK_SEQ_CNT_EN adds o_pkt_seq, a 16-bit count of
// completed packets (dropped ones included) latched alongside o_pkt_data.
//
// Ports:
//   i_clk        prop_clk (51.2 MHz)
//   i_rst_n      asynchronous active-low reset
//   i_enable     generate packets while high
//   i_dkdata     AGC DKDATA, same clock domain
//   o_dkstrt     packet start pulse
//   o_dkbsnc     bit sync pulse
//   o_dkend      packet end pulse
//   o_pkt_data   assembled packet, first bit received in the MSB
//   o_pkt_valid  o_pkt_data holds an unread packet
//   i_pkt_ready  consumer accepts o_pkt_data
//   o_overrun    sticky: a packet was dropped
//   i_clr_ovr    synchronous clear of o_overrun (a same-cycle drop wins)
//   o_busy       a packet sequence is in progress
//   o_pkt_seq    (DNLINK_SEQ_CNT_EN only) sequence number of o_pkt_data
// -----------------------------------------------------------------------------
module dnlink_pcm_sim #(
    parameter int BIT_DIV         = 1000,
    parameter int PULSE_LEN       = 50,
    parameter int NBITS           = 40,
    parameter int PKT_PERIOD_BITS = 512
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_dkdata,
    output logic             o_dkstrt,
    output logic             o_dkbsnc,
    output logic             o_dkend,
    output logic [NBITS-1:0] o_pkt_data,
    output logic             o_pkt_valid,
    input  logic             i_pkt_ready,
    output logic             o_overrun,
    input  logic             i_clr_ovr,
    output logic             o_busy
`ifdef DNLINK_SEQ_CNT_EN
    ,
    output logic [15:0]      o_pkt_seq
`endif
);

    localparam int PER_CLKS = PKT_PERIOD_BITS * BIT_DIV;
    localparam int PER_W    = $clog2(PER_CLKS);
    localparam int PH_W     = $clog2(BIT_DIV);
    localparam int SLOT_W   = $clog2(NBITS + 2);

    localparam logic [PER_W-1:0]  PER_LAST     = PER_W'(PER_CLKS - 1);
    localparam logic [PH_W-1:0]   PH_LAST      = PH_W'(BIT_DIV - 1);
    localparam logic [PH_W-1:0]   PH_PEND      = PH_W'(PULSE_LEN - 1);
    localparam logic [SLOT_W-1:0] SLOT_LASTBIT = SLOT_W'(NBITS);

    // A packet is NBITS+2 slots of BIT_DIV clocks: slot 0 carries DKSTRT,
    // slots 1..NBITS carry DKBSNC for bit slot-1, slot NBITS+1 carries DKEND.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_END,
        S_LOAD
    } state_t;

    state_t             r_state;
    logic [PH_W-1:0]    r_ph;
    logic [SLOT_W-1:0]  r_slot;
    logic [PER_W-1:0]   r_per;
    logic               r_run;
    logic [NBITS-1:0]   r_shreg;
    logic               r_dkstrt;
    logic               r_dkbsnc;
    logic               r_dkend;
    logic               r_busy;
    logic [NBITS-1:0]   r_pkt_data;
    logic               r_pkt_valid;
    logic               r_overrun;

    logic               w_start;
    logic               w_load;
    logic               w_drop;
    logic [NBITS-1:0]   w_shift;

    // r_run marks a continuous enabled stretch; while it is set, a new packet
    // waits for the period counter to wrap. Seeing enable low in IDLE clears
    // it, so re-raising enable starts a packet on the very next clock.
    assign w_start = (r_state == S_IDLE) && i_enable && (!r_run || (r_per == PER_LAST));
    assign w_load  = (r_state == S_LOAD);
    assign w_drop  = w_load && r_pkt_valid && !i_pkt_ready;

    generate
        if (NBITS == 1) begin : g_shift_one
            assign w_shift = i_dkdata;
        end else begin : g_shift_many
            assign w_shift = {r_shreg[NBITS-2:0], i_dkdata};
        end
    endgenerate

    // Period counter: 0 on the first START clock, wraps every packet period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run <= 1'b0;
            r_per <= '0;
        end else if (w_start) begin
            r_run <= 1'b1;
            r_per <= '0;
        end else if ((r_state == S_IDLE) && !i_enable) begin
            r_run <= 1'b0;
            r_per <= '0;
        end else if (r_run) begin
            r_per <= (r_per == PER_LAST) ? '0 : r_per + 1'b1;
        end
    end

    // Sequencer. Pulses are set on the clock a slot begins and cleared after
    // PULSE_LEN clocks; only one pulse can be live in any slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_ph     <= '0;
            r_slot   <= '0;
            r_shreg  <= '0;
            r_dkstrt <= 1'b0;
            r_dkbsnc <= 1'b0;
            r_dkend  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_START;
                        r_ph     <= '0;
                        r_slot   <= '0;
                        r_dkstrt <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_START, S_BITS, S_END: begin
                    if (r_ph == PH_PEND) begin
                        r_dkstrt <= 1'b0;
                        r_dkbsnc <= 1'b0;
                        r_dkend  <= 1'b0;
                        if (r_state == S_END) begin
                            r_state <= S_LOAD;
                            r_busy  <= 1'b0;
                        end
                    end
                    if (r_ph == PH_LAST) begin
                        r_ph   <= '0;
                        r_slot <= r_slot + 1'b1;
                        // last clock of a bit slot: sample DKDATA
                        if (r_state == S_BITS) begin
                            r_shreg <= w_shift;
                        end
                        if (r_slot < SLOT_LASTBIT) begin
                            r_state  <= S_BITS;
                            r_dkbsnc <= 1'b1;
                        end else begin
                            r_state <= S_END;
                            r_dkend <= 1'b1;
                        end
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // One-entry output buffer; a load may coincide with a transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pkt_data  <= '0;
            r_pkt_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load && !w_drop) begin
                r_pkt_data  <= r_shreg;
                r_pkt_valid <= 1'b1;
            end else if (r_pkt_valid && i_pkt_ready) begin
                r_pkt_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef DNLINK_SEQ_CNT_EN
    logic [15:0] r_seq_cnt;
    logic [15:0] r_pkt_seq;

    // Counts every completed packet, so a gap seen by the monitor means drops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seq_cnt <= '0;
            r_pkt_seq <= '0;
        end else if (w_load) begin
            r_seq_cnt <= r_seq_cnt + 16'd1;
            if (!w_drop) begin
                r_pkt_seq <= r_seq_cnt;
            end
        end
    end

    assign o_pkt_seq = r_pkt_seq;
`endif

    assign o_dkstrt    = r_dkstrt;
    assign o_dkbsnc    = r_dkbsnc;
    assign o_dkend     = r_dkend;
    assign o_busy      = r_busy;
    assign o_pkt_data  = r_pkt_data;
    assign o_pkt_valid = r_pkt_valid;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_dnlink_pcm_sim.sv
// -----------------------------------------------------------------------------
// tb_dnlink_pcm_sim
// Directed scenarios plus a randomized run of dnlink_pcm_sim with small
// parameters. A time-based reference model (packet-relative time t, plain
// arithmetic for pulse windows, sample points and the buffer rules) predicts
// every output on every clock.
// -----------------------------------------------------------------------------
module tb_dnlink_pcm_sim;

    localparam int BD    = 8;
    localparam int PL    = 2;
    localparam int N     = 8;
    localparam int P     = 16;
    localparam int PER   = P * BD;
    localparam int LOADT = (N + 1) * BD + PL;   // packet time of the load clock

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         dkdata = 1'b0;
    logic         pkt_ready = 1'b0;
    logic         clr_ovr = 1'b0;
    logic         dkstrt, dkbsnc, dkend, pkt_valid, overrun, busy;
    logic [N-1:0] pkt_data;
`ifdef DNLINK_SEQ_CNT_EN
    logic [15:0]  pkt_seq;
    logic [15:0]  obs_seq = '0;
    logic [15:0]  m_seq, m_cnt;
    int           seq_k = 0;
    bit           seq_on = 1'b0;
`endif

    dnlink_pcm_sim #(
        .BIT_DIV(BD), .PULSE_LEN(PL), .NBITS(N), .PKT_PERIOD_BITS(P)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_dkdata(dkdata),
        .o_dkstrt(dkstrt), .o_dkbsnc(dkbsnc), .o_dkend(dkend),
        .o_pkt_data(pkt_data), .o_pkt_valid(pkt_valid), .i_pkt_ready(pkt_ready),
        .o_overrun(overrun), .i_clr_ovr(clr_ovr), .o_busy(busy)
`ifdef DNLINK_SEQ_CNT_EN
        , .o_pkt_seq(pkt_seq)
`endif
    );

    always #5 clk = ~clk;

    int           n_tot = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           base = 0;
    int           n_xfer = 0;
    logic         obs_valid = 1'b0;
    logic [N-1:0] pat = '0;
    logic [N-1:0] pat_q[$];

    // reference model state
    int           m_t = -1;       // packet-relative time of current clock, -1 idle
    bit           m_run = 1'b0;
    int           m_start = 0;
    logic [N-1:0] m_word = '0;
    logic [N-1:0] m_data = '0;
    bit           m_valid = 1'b0;
    bit           m_ovr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model over the clock that just ended, using its inputs.
    task automatic model_step();
        bit ld, drop;
        if (!rst_n) begin
            m_t = -1; m_run = 0; m_word = '0; m_data = '0; m_valid = 0; m_ovr = 0;
`ifdef DNLINK_SEQ_CNT_EN
            m_seq = '0; m_cnt = '0;
`endif
            return;
        end
        if (m_t >= 2*BD-1 && m_t <= (N+1)*BD-1 && (m_t % BD) == BD-1)
            m_word = {m_word[N-2:0], dkdata};
        ld   = (m_t == LOADT);
        drop = ld && m_valid && !pkt_ready;
        if (ld && !drop) begin
            m_data = m_word; m_valid = 1;
`ifdef DNLINK_SEQ_CNT_EN
            m_seq = m_cnt;
`endif
        end else if (m_valid && pkt_ready) begin
            m_valid = 0;
        end
`ifdef DNLINK_SEQ_CNT_EN
        if (ld) m_cnt = m_cnt + 16'd1;
`endif
        if (drop) m_ovr = 1;
        else if (clr_ovr) m_ovr = 0;
        if (m_t >= 0) begin
            m_t++;
            if (m_t > LOADT) m_t = -1;
        end else if (!enable) begin
            m_run = 0;
        end else if (!m_run || (cyc - m_start) == PER-1) begin
            m_t = 0; m_run = 1; m_start = cyc + 1;
        end
    endtask

    task automatic tick();
        logic e_strt, e_bsnc, e_end, e_busy;
        if (rst_n && obs_valid && pkt_ready) begin
            n_xfer++;
`ifdef DNLINK_SEQ_CNT_EN
            if (seq_on) begin
                chk("seq", 64'(obs_seq), 64'(seq_k));
                seq_k++;
            end
`endif
        end
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        e_strt = (m_t >= 0 && m_t < PL);
        e_bsnc = (m_t >= BD && m_t < (N+1)*BD && (m_t % BD) < PL);
        e_end  = (m_t >= (N+1)*BD && m_t < LOADT);
        e_busy = (m_t >= 0 && m_t < LOADT);
        chk("dkstrt", 64'(dkstrt), 64'(e_strt));
        chk("dkbsnc", 64'(dkbsnc), 64'(e_bsnc));
        chk("dkend", 64'(dkend), 64'(e_end));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("pkt_valid", 64'(pkt_valid), 64'(m_valid));
        chk("pkt_data", 64'(pkt_data), 64'(m_data));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        chk("mutex", 64'(int'(dkstrt) + int'(dkbsnc) + int'(dkend) > 1), 64'(0));
`ifdef DNLINK_SEQ_CNT_EN
        chk("pkt_seq", 64'(pkt_seq), 64'(m_seq));
        obs_seq = pkt_seq;
`endif
        obs_valid = pkt_valid;
        // drive DKDATA for this clock: packet pattern inside the bit window
        if (m_t == 0) pat = (pat_q.size() > 0) ? pat_q.pop_front() : N'($urandom);
        if (m_t >= BD && m_t < (N+1)*BD) dkdata = pat[N-1-(m_t/BD-1)];
        else dkdata = 1'($urandom_range(0, 1));
    endtask

    task automatic run_rel(input int rel);
        while (cyc - base < rel) tick();
    endtask

    task automatic do_reset();
        rst_n = 0; enable = 0; pkt_ready = 0; clr_ovr = 0;
        tick(); tick();
        chk("rst_valid", 64'(pkt_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ovr", 64'(overrun), 64'(0));
        rst_n = 1; n_xfer = 0; pat_q.delete();
    endtask

    // start a packet on the next clock and make that clock t=0
    task automatic kick();
        enable = 1;
        tick();
        base = cyc;
    endtask

    initial begin
        bit rdy_mode;

        // nominal packet, pattern A5, consumer always ready
        do_reset();
        pkt_ready = 1; pat_q.push_back(8'hA5);
        kick();
        chk("a_strt_t0", 64'(dkstrt), 64'(1));
        run_rel(1);   chk("a_strt_t1", 64'(dkstrt), 64'(1));
        run_rel(2);   chk("a_strt_t2", 64'(dkstrt), 64'(0));
        run_rel(8);   chk("a_bsnc_t8", 64'(dkbsnc), 64'(1));
        run_rel(72);  chk("a_end_t72", 64'(dkend), 64'(1));
        run_rel(73);  chk("a_end_t73", 64'(dkend), 64'(1));
        run_rel(74);  chk("a_valid_t74", 64'(pkt_valid), 64'(0));
        run_rel(75);  chk("a_valid_t75", 64'(pkt_valid), 64'(1));
                      chk("a_data_t75", 64'(pkt_data), 64'(8'hA5));
        run_rel(127); chk("a_strt_t127", 64'(dkstrt), 64'(0));
        run_rel(128); chk("a_strt_t128", 64'(dkstrt), 64'(1));
        run_rel(PER + 77);
        chk("a_xfers", 64'(n_xfer), 64'(2));
        chk("a_ovr", 64'(overrun), 64'(0));

        // three packets with no consumer
        do_reset();
        pat_q.push_back(8'h01); pat_q.push_back(8'h02); pat_q.push_back(8'h03);
        kick();
        run_rel(2*PER + 76);
        chk("b_data", 64'(pkt_data), 64'(8'h01));
        chk("b_valid", 64'(pkt_valid), 64'(1));
        chk("b_ovr", 64'(overrun), 64'(1));
        enable = 0; clr_ovr = 1; tick(); clr_ovr = 0;
        chk("b_ovr_clr", 64'(overrun), 64'(0));
        chk("b_valid_kept", 64'(pkt_valid), 64'(1));
        pkt_ready = 1; tick(); pkt_ready = 0;
        chk("b_xfer_valid", 64'(pkt_valid), 64'(0));
        chk("b_xfers", 64'(n_xfer), 64'(1));

        // enable dropped mid-packet
        do_reset();
        pkt_ready = 1;
        kick();
        run_rel(30);  enable = 0;
        run_rel(72);  chk("c_end_t72", 64'(dkend), 64'(1));
        run_rel(128); chk("c_nostrt_t128", 64'(dkstrt), 64'(0));
                      chk("c_idle_t128", 64'(busy), 64'(0));
        run_rel(140);

        // asynchronous reset mid-packet
        do_reset();
        kick();
        run_rel(40);
        chk("d_bsnc_t40", 64'(dkbsnc), 64'(1));
        rst_n = 0;
        #1;
        chk("d_rst_bsnc", 64'(dkbsnc), 64'(0));
        chk("d_rst_strt", 64'(dkstrt), 64'(0));
        chk("d_rst_end", 64'(dkend), 64'(0));
        chk("d_rst_busy", 64'(busy), 64'(0));
        chk("d_rst_valid", 64'(pkt_valid), 64'(0));
        tick();
        rst_n = 1;
        kick();
        chk("d_restart", 64'(dkstrt), 64'(1));
        run_rel(75);  chk("d_valid_t75", 64'(pkt_valid), 64'(1));
        run_rel(80);

        // clear and drop on the same clock
        do_reset();
        kick();
        run_rel(PER + LOADT - 1); chk("e_ovr_pre", 64'(overrun), 64'(0));
        run_rel(PER + LOADT);
        clr_ovr = 1; tick(); clr_ovr = 0;
        chk("e_ovr_set_wins", 64'(overrun), 64'(1));
        run_rel(PER + LOADT + 8);

        // three transfers with consumer ready
        do_reset();
        pkt_ready = 1;
`ifdef DNLINK_SEQ_CNT_EN
        seq_on = 1; seq_k = 0;
`endif
        kick();
        run_rel(3*PER);
        chk("f_xfers", 64'(n_xfer), 64'(3));
`ifdef DNLINK_SEQ_CNT_EN
        chk("f_seq_count", 64'(seq_k), 64'(3));
        seq_on = 0;
`endif

        // randomized run: bursty consumer, occasional enable toggles and resets
        do_reset();
        enable = 1; rdy_mode = 1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) enable = !enable;
            if ($urandom_range(0, 63) == 0) rdy_mode = !rdy_mode;
            pkt_ready = rdy_mode && ($urandom_range(0, 1) == 1);
            clr_ovr = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 1499) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/dnlink_pcm_sim.md
Name: dnlink_pcm_sim

Overview:
- Simulated PCM telemetry end of the AGC downlink interface. Plays the spacecraft telemetry system that the FPGA AGC's downlink outputs talk to.
- Generates the DKSTRT, DKBSNC and DKEND timing pulses that the AGC consumes, and samples the AGC's DKDATA output bit-serially.
- Assembles each downlink packet into a word and hands it to the monitor, which forwards it over the UART, using a valid/ready handshake.
- Runs on prop_clk (51.2 MHz). Its three outputs replace the debounced dkstrt_in/dkend_in/dkbsnc_in pins when the board has no external telemetry unit.

Parameters:
- BIT_DIV, 1000: clocks per downlink bit time (51.2 MHz / 1000 = 51.2 kbit/s).
- PULSE_LEN, 50: clocks that each DKSTRT/DKBSNC/DKEND pulse stays high; legal range 1 to BIT_DIV-2.
- NBITS, 40: bits per packet; legal range 1 to 64.
- PKT_PERIOD_BITS, 512: bit times from one DKSTRT rising edge to the next (default gives 100 packets/s); must be >= NBITS+3.

Ports:
- clk  in  1  prop_clk.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  when high, packets are generated.
- dkdata  in  1  AGC DKDATA; synchronous to clk (same clock domain).
- dkstrt  out  1  packet start pulse to the AGC.
- dkbsnc  out  1  bit sync pulse to the AGC.
- dkend  out  1  packet end pulse to the AGC.
- pkt_data  out  NBITS  assembled packet; first-received bit is the MSB.
- pkt_valid  out  1  pkt_data holds an unread packet.
- pkt_ready  in  1  consumer accepts pkt_data.
- overrun  out  1  sticky flag: a packet was dropped.
- clr_ovr  in  1  synchronous clear of overrun.
- busy  out  1  a packet sequence is in progress.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset is asynchronous; asserting it mid-packet aborts the packet immediately with no pulse tails.
- Timing base: t=0 is the clock on which the packet starts. Bit index i runs 0 to NBITS-1.
- States and timing:
  - IDLE: when enable=1 and the period counter is 0, go to START at t=0. busy=1 from t=0 until the end of END.
  - START: dkstrt is high during t=[0, PULSE_LEN).
  - BITS, bit i:
    - dkbsnc is high during t=[(i+1)·BIT_DIV, (i+1)·BIT_DIV+PULSE_LEN).
    - dkdata is sampled at t=(i+2)·BIT_DIV-1 and shifted in MSB-first.
  - END: dkend is high during t=[(NBITS+1)·BIT_DIV, (NBITS+1)·BIT_DIV+PULSE_LEN).
  - After END deasserts: load the buffer, then return to IDLE.
- Period counter: free-runs from t=0 and wraps at PKT_PERIOD_BITS·BIT_DIV-1. The next START occurs at t=PKT_PERIOD_BITS·BIT_DIV if enable is still 1.
- Enable:
  - Dropping enable mid-packet does not abort; the current packet completes normally.
  - Raising enable in IDLE starts the next packet on the following clock and restarts the period counter.
- Output buffer (one entry):
  - pkt_valid rises on the clock after dkend falls.
  - pkt_data is stable while pkt_valid=1.
  - A transfer happens on a clock with pkt_valid & pkt_ready; pkt_valid drops on the next clock unless a new load happens on that same clock.
  - Load when pkt_valid=0, or when pkt_ready=1 on the same clock: the buffer takes the new packet and pkt_valid stays or becomes 1.
  - Load when pkt_valid=1 and pkt_ready=0: the new packet is dropped, the old one is kept, and overrun is set.
- Overrun: if clr_ovr and a drop happen on the same clock, overrun is set (set wins).
- Mutual exclusion: dkstrt, dkbsnc and dkend are never high together.

Optional Feature:
- Macro: DNLINK_SEQ_CNT_EN.
- Defined:
  - Adds output pkt_seq [15:0], latched together with pkt_data.
  - pkt_seq counts completed packets from 0, including dropped ones, and wraps 65535 to 0.
  - The monitor can detect dropped packets by gaps in the sequence.
  - Reset value is 0.
- Undefined: the port and its counter are absent.

Test Plan:
- All cases use BIT_DIV=8, PULSE_LEN=2, NBITS=8, PKT_PERIOD_BITS=16.
- Enable with dkdata driven from pattern 8'hA5, MSB first, changed right after each dkbsnc:
  - dkstrt is high at t=0–1;
  - dkbsnc is high at t=8·(i+1) to 8·(i+1)+1;
  - dkend is high at t=72–73;
  - pkt_valid rises at t=75 with pkt_data=8'hA5.
- Enable held with pkt_ready=1: the second dkstrt is at t=128; there are two transfers and overrun stays 0.
- pkt_ready=0 across three packets (8'h01, 8'h02, 8'h03): pkt_data stays 8'h01 and overrun=1. Then pulse clr_ovr and set pkt_ready=1: overrun clears and 8'h01 transfers.
- Drop enable at t=30: the packet completes (dkend at t=72) and there is no dkstrt at t=128.
- Assert rst_n=0 at t=40: all outputs are 0 immediately. Release it with enable=1: a new packet starts cleanly.
- Timed so clr_ovr and a drop land on the same clock: overrun stays 1. With DNLINK_SEQ_CNT_EN defined, pkt_seq goes 0, 1, 2 across the first three transfers.
